aes_key_expand: RTL and testbench

Iterative AES-128 key schedule that sits directly upstream of the AES round datapath. It accepts a 128-bit cipher key, computes round keys rk[1]..rk[10] at one per clock, and stores rk[0]..rk[10] in an internal register bank. A combinational read port lets the round controller fetch any round key for the round function's round_key_in.

---
 rtl/aes_key_expand.sv | 175 +++++++++++++++++
 tb/tb_aes_key_expand.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
`timescale 1ns/1ps
// AES forward S-box: byte substitution as a 256-entry lookup.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
module aes_sbox (
    input  logic [7:0] val,
    output logic [7:0] sub
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign sub = SBOX[val];

endmodule

// Iterative AES-128 key schedule: one round key per clock into an 11-entry bank.
// Latency: done pulses 10 cycles after start is accepted; rd_key is combinational.
// Backpressure: start is taken only while ready=1; requests while busy are dropped.
module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         ready,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
);

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;

    logic [127:0]   bank_q [0:NUM_ROUNDS];
    logic [127:0]   work_q;
    logic [3:0]     cnt_q;
    logic [7:0]     rcon_q;
    logic           done_q;
    logic           keys_valid_q;

    logic           accept;
    logic           step;
    logic           last;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    rot_w;
    logic [31:0]    sub_w;
    logic [31:0]    t_w;
    logic [31:0]    n0, n1, n2, n3;
    logic [127:0]   next_key;
    logic [7:0]     rcon_next;

    // State register; reset returns to IDLE from anywhere, abandoning a schedule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (cnt_q == 4'(NUM_ROUNDS)) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign done       = done_q;
    assign keys_valid = keys_valid_q;

    // One round of the schedule from the working key.
    assign w0    = work_q[127:96];
    assign w1    = work_q[95:64];
    assign w2    = work_q[63:32];
    assign w3    = work_q[31:0];
    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .val (rot_w[8*b +: 8]),
            .sub (sub_w[8*b +: 8])
        );
    end

    assign t_w       = sub_w ^ {rcon_q, 24'h0};
    assign n0        = w0 ^ t_w;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign next_key  = {n0, n1, n2, n3};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Bank, working key, round counter, rcon and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                bank_q[i] <= '0;
            end
            work_q       <= '0;
            cnt_q        <= '0;
            rcon_q       <= 8'h01;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            done_q <= last;
            if (accept) begin
                bank_q[0]    <= key_in;
                work_q       <= key_in;
                cnt_q        <= 4'd1;
                rcon_q       <= 8'h01;
                keys_valid_q <= 1'b0;
            end else if (step) begin
                bank_q[cnt_q] <= next_key;
                work_q        <= next_key;
                cnt_q         <= cnt_q + 4'd1;
                rcon_q        <= rcon_next;
                if (last) begin
                    keys_valid_q <= 1'b1;
                end
            end
        end
    end

    // Read port: out-of-range indices return zero.
    always_comb begin
        rd_key = '0;
        if (rd_idx <= 4'(NUM_ROUNDS)) begin
            rd_key = bank_q[rd_idx];
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
`timescale 1ns/1ps
module tb_aes_key_expand;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         ready;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]   ref_sbox [256];
    logic [127:0] exp_q [$];
    logic [127:0] key_q [$];
    int           acc_q [$];

    int           m_rem  = 0;
    logic         m_kv   = 1'b0;
    logic         m_done = 1'b0;

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .key_in     (key_in),
        .ready      (ready),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            ref_sbox[v] = s;
        end
    endtask

    // Textbook 44-word key expansion; pushes rk[0..10] onto the scoreboard.
    task automatic push_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {ref_sbox[tmp[31:24]], ref_sbox[tmp[23:16]],
                       ref_sbox[tmp[15:8]],  ref_sbox[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_q.push_back({w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
        key_q.push_back(k);
    endtask

    // Monitor: compares status against a cycle model and sweeps the bank on done.
    initial begin
        logic         s_start;
        logic [127:0] s_key;
        logic [127:0] k0;
        logic [127:0] expk;
        int           acc;
        rd_idx = 4'd0;
        forever begin
            @(negedge clk);
            s_start = start;
            s_key   = key_in;
            if (!rst_n) begin
                m_rem  = 0;
                m_kv   = 1'b0;
                m_done = 1'b0;
                exp_q.delete();
                key_q.delete();
                acc_q.delete();
                check("rst_ready", ready, 1);
                check("rst_keys_valid", keys_valid, 0);
                check("rst_done", done, 0);
                for (int i = 0; i < 16; i++) begin
                    rd_idx = 4'(i);
                    #0.2;
                    check("rst_rd_key", rd_key, 0);
                end
            end else begin
                check("ready", ready, m_rem == 0);
                check("keys_valid", keys_valid, m_kv);
                check("done", done, m_done);
                if (done) begin
                    if (exp_q.size() < 11) begin
                        n_checks++;
                        $display("FAIL unexpected_done: done=1 with no expansion pending (cycle %0d)", cyc);
                    end else begin
                        k0  = key_q.pop_front();
                        acc = acc_q.pop_front();
                        check("latency", 128'(cyc - acc), 10);
                        for (int i = 0; i < 16; i++) begin
                            rd_idx = 4'(i);
                            #0.2;
                            expk = (i <= 10) ? exp_q.pop_front() : 128'h0;
                            check("rk_sweep", rd_key, expk);
                            if (k0 == FIPS_KEY && i == 1)  check("fips_rk1", rd_key, FIPS_RK1);
                            if (k0 == FIPS_KEY && i == 10) check("fips_rk10", rd_key, FIPS_RK10);
                            if (k0 == 128'h0 && i == 1)    check("zero_rk1", rd_key, ZERO_RK1);
                            if (k0 == 128'h0 && i == 10)   check("zero_rk10", rd_key, ZERO_RK10);
                        end
                    end
                end
                if (m_rem == 0 && s_start) begin
                    push_schedule(s_key);
                    acc_q.push_back(cyc + 1);
                    m_rem  = 10;
                    m_kv   = 1'b0;
                    m_done = 1'b0;
                end else if (m_rem > 0) begin
                    m_rem--;
                    m_done = (m_rem == 0);
                    if (m_rem == 0) m_kv = 1'b1;
                end else begin
                    m_done = 1'b0;
                end
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready();
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ready_timeout: ready=%0b expected 1 within 60 cycles", ready);
        end
    endtask

    task automatic start_key(input logic [127:0] k);
        wait_ready();
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = rand128();
    endtask

    task automatic wait_idle();
        wait_ready();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Stimulus.
    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        key_in = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // FIPS-197 vector, then all-zero key.
        start_key(FIPS_KEY);
        wait_idle();
        start_key(128'h0);
        wait_idle();

        // Start held for 15 cycles with key_in churning after accept.
        wait_ready();
        start  = 1'b1;
        key_in = rand128();
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            key_in = rand128();
        end
        start = 1'b0;
        wait_idle();

        // Reset mid-expansion, then a clean FIPS run.
        start_key(FIPS_KEY);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start_key(FIPS_KEY);
        wait_idle();

        // Back-to-back A then B.
        start_key(rand128());
        start_key(rand128());
        wait_idle();

        // Random keys with random gaps.
        for (int n = 0; n < 6; n++) begin
            start_key(rand128());
            repeat ($urandom_range(0, 12)) @(posedge clk);
            #1;
        end
        wait_idle();

        for (int i = 0; i < 30 && (exp_q.size() != 0 || m_rem != 0); i++) @(posedge clk);
        check("drain_pending", 128'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
